tristate_bus_arbiter: RTL

//  Shares one WIDTH-bit tristate bus between NUM_REQ requesters. Grants at most one owner at a time
//  (round-robin), enforces a hold limit and a turnaround gap, and produces registered drive/d vectors.

---
 rtl/tristate_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus, with hold limit and turnaround gap.
// Ports: clk, reset, req, wen, wdata in; grant, owner, busy, forced_release, drive, d out.
module tristate_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wen,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       forced_release,
  output logic [WIDTH-1:0]           drive,
  output logic [WIDTH-1:0]           d
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [OW:0]   NR   = (OW + 1)'(NUM_REQ);
  localparam logic [3:0]    TINIT =
    (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t               state, state_n;
  logic [OW-1:0]        rr_ptr, rr_ptr_n;
  logic [OW-1:0]        owner_n, win, ptr_inc;
  logic [HW-1:0]        hold_cnt, hold_n;
  logic [3:0]           turn_cnt, turn_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic                 fr_n;
  logic [WIDTH-1:0]     drive_n, d_n;
  logic [WIDTH-1:0]     own_wen, own_wdata;
  logic                 own_req, others, rel_a, rel_b;

  // Scan from the highest offset down so the last hit is the
  // first requester at or after rr_ptr.
  always_comb begin
    logic [OW:0] sum;
    win = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (OW + 1)'(i);
      if (sum >= NR) sum = sum - NR;
      if (req[sum[OW-1:0]]) win = sum[OW-1:0];
    end
  end

  always_comb begin
    own_wen   = '0;
    own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) begin
        own_wen   = wen[i*WIDTH +: WIDTH];
        own_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign own_req = req[owner];
  // grant is onehot(owner) while OWNED, so it masks out the owner.
  assign others  = |(req & ~grant);
  assign rel_a   = !own_req;
  assign rel_b   = (hold_cnt == HMAX) && others;
  assign ptr_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    hold_n   = hold_cnt;
    turn_n   = turn_cnt;
    fr_n     = 1'b0;
    drive_n  = '0;
    d_n      = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_n = NUM_REQ'(1) << win;
          owner_n = win;
          hold_n  = HW'(1);
          state_n = OWNED;
        end
      end
      OWNED: begin
        if (own_req) begin
          drive_n = own_wen;
          d_n     = own_wdata & own_wen;
        end
        if (rel_a || rel_b) begin
          grant_n  = '0;
          rr_ptr_n = ptr_inc;
          fr_n     = rel_b && !rel_a;
          if (TURNAROUND > 0) begin
            state_n = TURN;
            turn_n  = TINIT;
          end else begin
            state_n = IDLE;
          end
        end else if (hold_cnt != HMAX) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == 4'd0) state_n = IDLE;
        else turn_n = turn_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      hold_cnt       <= '0;
      turn_cnt       <= '0;
      forced_release <= 1'b0;
      drive          <= '0;
      d              <= '0;
    end else begin
      state          <= state_n;
      grant          <= grant_n;
      owner          <= owner_n;
      rr_ptr         <= rr_ptr_n;
      hold_cnt       <= hold_n;
      turn_cnt       <= turn_n;
      forced_release <= fr_n;
      drive          <= drive_n;
      d              <= d_n;
    end
  end

endmodule
